// File: rtl/mmio_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mmio_access_ctrl_if
// CPU load/store bus between the pipeline's memory stage and the access
// controller.
//   req_read / req_write : load / store in the current instruction
//   req_addr / req_wdata : byte address and store data, held while stalled
//   stall                : freezes PC and pipeline
//   rdata / rdata_valid  : registered load result and its writeback strobe
// Modports: master = CPU side, slave = controller side.
// ---------------------------------------------------------------------------
interface mmio_access_ctrl_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  stall, rdata, rdata_valid
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output stall, rdata, rdata_valid
  );
endinterface

// File: rtl/mmio_access_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_access_ctrl
// Sequences CPU loads/stores onto data memory and the board IO (LED, segment
// display, switches, keys, confirm button). Stalls the CPU for memory read
// latency and for confirm-button handshakes on switch/key reads.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   bus             : CPU request/response bus (slave modport)
//   mem_rdata       : data memory read data
//   switch_data     : switch levels
//   key_data        : key code
//   conf_btn        : raw confirm button, asynchronous to clk
//   mem_re / mem_we : data memory read / write enables
//   led_we / seg_we : single-cycle IO load strobes
//   wdata           : store data towards memory and IO
//   btn_level       : debounced confirm-button level
// ---------------------------------------------------------------------------
module mmio_access_ctrl #(
  parameter int          MEM_WAIT        = 1,
  parameter int          DEBOUNCE_CYCLES = 20,
  parameter logic [31:0] LED_ADDR        = 32'hFFFF_FC60,
  parameter logic [31:0] SWITCH_ADDR     = 32'hFFFF_FC70,
  parameter logic [31:0] KEY_ADDR        = 32'hFFFF_FC74,
  parameter logic [31:0] SEG_ADDR        = 32'hFFFF_FC80,
  parameter logic [31:0] BTN_ADDR        = 32'hFFFF_FC84
) (
  input  logic                clk,
  input  logic                rst_n,
  mmio_access_ctrl_if.slave   bus,
  input  logic [31:0]         mem_rdata,
  input  logic [15:0]         switch_data,
  input  logic [4:0]          key_data,
  input  logic                conf_btn,
  output logic                mem_re,
  output logic                mem_we,
  output logic                led_we,
  output logic                seg_we,
  output logic [31:0]         wdata,
  output logic                btn_level
);

  localparam int WAIT_W = $clog2(MEM_WAIT + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_WAIT,
    S_BTN_PRESS,
    S_BTN_RELEASE,
    S_DONE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DB_W-1:0]   db_cnt;
  logic              sync_ff1;
  logic              sync_ff2;
  logic              btn_prev;
  logic              sel_key;

  logic is_io;
  logic hit_led;
  logic hit_seg;
  logic hit_sw;
  logic hit_key;
  logic hit_btn;
  logic do_read;
  logic do_write;
  logic accept_read;
  logic idle_write;

  // Address decode; a simultaneous read and write is treated as a write only.
  assign is_io       = (bus.req_addr[31:10] == 22'h3FFFFF);
  assign hit_led     = is_io && (bus.req_addr == LED_ADDR);
  assign hit_seg     = is_io && (bus.req_addr == SEG_ADDR);
  assign hit_sw      = is_io && (bus.req_addr == SWITCH_ADDR);
  assign hit_key     = is_io && (bus.req_addr == KEY_ADDR);
  assign hit_btn     = is_io && (bus.req_addr == BTN_ADDR);
  assign do_write    = bus.req_write;
  assign do_read     = bus.req_read && !bus.req_write;
  assign accept_read = (state == S_IDLE) && do_read;
  assign idle_write  = (state == S_IDLE) && do_write;

  // Combinational strobes; qualified by rst_n so every output reads 0 while
  // reset is held, even if the CPU keeps a request asserted.
  assign bus.stall = rst_n && (accept_read || (state == S_MEM_WAIT) ||
                               (state == S_BTN_PRESS) || (state == S_BTN_RELEASE));
  assign mem_re    = rst_n && ((accept_read && !is_io) || (state == S_MEM_WAIT));
  assign mem_we    = rst_n && idle_write && !is_io;
  assign led_we    = rst_n && idle_write && hit_led;
  assign seg_we    = rst_n && idle_write && hit_seg;
  assign wdata     = bus.req_wdata;

  // Button front end: two-flop synchronizer, then a counter that only flips
  // btn_level once the synchronized input has disagreed with it for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1  <= 1'b0;
      sync_ff2  <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_ff1 <= conf_btn;
      sync_ff2 <= sync_ff1;
      if (sync_ff2 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_level <= ~btn_level;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Access sequencer. btn_prev follows btn_level one cycle late so that only
  // a 0->1 edge seen while waiting in BTN_PRESS confirms a switch/key read;
  // a button already held on entry must be released and pressed again.
  // rdata_valid is raised on every transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      btn_prev        <= 1'b0;
      sel_key         <= 1'b0;
    end else begin
      btn_prev        <= btn_level;
      bus.rdata_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (do_read) begin
            if (!is_io) begin
              wait_cnt <= WAIT_W'(1);
              state    <= S_MEM_WAIT;
            end else if (hit_sw || hit_key) begin
              sel_key <= hit_key;
              state   <= S_BTN_PRESS;
            end else begin
              bus.rdata       <= hit_btn ? {31'b0, btn_level} : 32'b0;
              bus.rdata_valid <= 1'b1;
              state           <= S_DONE;
            end
          end
        end
        S_MEM_WAIT: begin
          if (wait_cnt == WAIT_W'(MEM_WAIT)) begin
            bus.rdata       <= mem_rdata;
            bus.rdata_valid <= 1'b1;
            wait_cnt        <= '0;
            state           <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_BTN_PRESS: begin
          if (btn_level && !btn_prev) begin
            bus.rdata <= sel_key ? {27'b0, key_data} : {16'b0, switch_data};
            state     <= S_BTN_RELEASE;
          end
        end
        S_BTN_RELEASE: begin
          if (!btn_level) begin
            bus.rdata_valid <= 1'b1;
            state           <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_access_ctrl
// Directed bench for mmio_access_ctrl with MEM_WAIT=2, DEBOUNCE_CYCLES=20.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_mmio_access_ctrl;

  localparam logic [31:0] LED_A = 32'hFFFF_FC60;
  localparam logic [31:0] SW_A  = 32'hFFFF_FC70;
  localparam logic [31:0] KEY_A = 32'hFFFF_FC74;
  localparam logic [31:0] SEG_A = 32'hFFFF_FC80;
  localparam logic [31:0] BTN_A = 32'hFFFF_FC84;
  localparam logic [31:0] UNM_A = 32'hFFFF_FC90;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_rdata;
  logic [15:0] switch_data;
  logic [4:0]  key_data;
  logic        conf_btn;
  logic        mem_re;
  logic        mem_we;
  logic        led_we;
  logic        seg_we;
  logic [31:0] wdata;
  logic        btn_level;

  int checks = 0;
  int errors = 0;

  mmio_access_ctrl_if bus ();

  mmio_access_ctrl #(
    .MEM_WAIT        (2),
    .DEBOUNCE_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .mem_rdata   (mem_rdata),
    .switch_data (switch_data),
    .key_data    (key_data),
    .conf_btn    (conf_btn),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .led_we      (led_we),
    .seg_we      (seg_we),
    .wdata       (wdata),
    .btn_level   (btn_level)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop in case the design wedges in a way the bounded loops miss.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wd);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_rdata   = 32'h0;
    switch_data = 16'h0;
    key_data    = 5'h0;
    conf_btn    = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state, including a read held high while in reset.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    checkOutput("rst_stall", bus.stall, 1'b0);
    checkOutput("rst_mem_re", mem_re, 1'b0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    checkOutput("rst_valid", bus.rdata_valid, 1'b0);
    checkOutput("rst_btn_level", btn_level, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Memory load with two wait cycles.
    mem_rdata = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    checkOutput("ml_c0_stall", bus.stall, 1'b1);
    checkOutput("ml_c0_mem_re", mem_re, 1'b1);
    nextCycle();
    checkOutput("ml_c1_stall", bus.stall, 1'b1);
    checkOutput("ml_c1_mem_re", mem_re, 1'b1);
    nextCycle();
    checkOutput("ml_c2_stall", bus.stall, 1'b1);
    checkOutput("ml_c2_valid", bus.rdata_valid, 1'b0);
    nextCycle();
    checkOutput("ml_c3_valid", bus.rdata_valid, 1'b1);
    checkOutput("ml_c3_rdata", bus.rdata, 32'hDEADBEEF);
    checkOutput("ml_c3_stall", bus.stall, 1'b0);
    checkOutput("ml_c3_no_reaccept", mem_re, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("ml_c4_valid", bus.rdata_valid, 1'b0);

    // Back-to-back IO stores, then a memory store, a read/write conflict
    // and a store to the switch address.
    applyStimulus(1'b0, 1'b1, LED_A, 32'h0000_00A5);
    #1;
    checkOutput("st_led_we", led_we, 1'b1);
    checkOutput("st_led_seg_we", seg_we, 1'b0);
    checkOutput("st_led_mem_we", mem_we, 1'b0);
    checkOutput("st_led_wdata", wdata, 32'h0000_00A5);
    checkOutput("st_led_stall", bus.stall, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, SEG_A, 32'h0000_1234);
    #1;
    checkOutput("st_seg_we", seg_we, 1'b1);
    checkOutput("st_seg_led_we", led_we, 1'b0);
    checkOutput("st_seg_wdata", wdata, 32'h0000_1234);
    checkOutput("st_seg_stall", bus.stall, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA);
    #1;
    checkOutput("st_conf_mem_we", mem_we, 1'b1);
    checkOutput("st_conf_mem_re", mem_re, 1'b0);
    checkOutput("st_conf_stall", bus.stall, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, SW_A, 32'h1);
    #1;
    checkOutput("st_sw_mem_we", mem_we, 1'b0);
    checkOutput("st_sw_led_we", led_we, 1'b0);
    checkOutput("st_sw_seg_we", seg_we, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("st_idle_led_we", led_we, 1'b0);
    checkOutput("st_idle_seg_we", seg_we, 1'b0);

    // Unmapped IO read returns 0 after one stall cycle.
    nextCycle();
    applyStimulus(1'b1, 1'b0, UNM_A, 32'h0);
    #1;
    checkOutput("unm_c0_stall", bus.stall, 1'b1);
    checkOutput("unm_c0_mem_re", mem_re, 1'b0);
    nextCycle();
    checkOutput("unm_c1_valid", bus.rdata_valid, 1'b1);
    checkOutput("unm_c1_rdata", bus.rdata, 32'h0);
    checkOutput("unm_c1_stall", bus.stall, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

    // Switch load: 50-cycle press, capture at debounced press, valid after
    // the debounced release.
    nextCycle();
    switch_data = 16'hBEEF;
    applyStimulus(1'b1, 1'b0, SW_A, 32'h0);
    #1;
    checkOutput("sw_accept_stall", bus.stall, 1'b1);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("sw_wait_stall", bus.stall, 1'b1);
      checkOutput("sw_wait_valid", bus.rdata_valid, 1'b0);
    end
    conf_btn = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      nextCycle();
      checkOutput("sw_press_stall", bus.stall, 1'b1);
      checkOutput("sw_press_level", btn_level, (i >= 22));
      checkOutput("sw_press_valid", bus.rdata_valid, 1'b0);
      if (i == 23) checkOutput("sw_capture", bus.rdata, 32'h0000_BEEF);
      if (i == 24) switch_data = 16'h1111;
    end
    conf_btn = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      nextCycle();
      checkOutput("sw_rel_valid", bus.rdata_valid, (j == 23));
      checkOutput("sw_rel_stall", bus.stall, (j < 23));
      if (j == 10) checkOutput("sw_hold_rdata", bus.rdata, 32'h0000_BEEF);
      if (j == 23) begin
        checkOutput("sw_done_rdata", bus.rdata, 32'h0000_BEEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      end
    end

    // Bounce rejection on a key load, then a clean press completes it.
    key_data = 5'h0A;
    applyStimulus(1'b1, 1'b0, KEY_A, 32'h0);
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0) conf_btn = ~conf_btn;
      nextCycle();
      checkOutput("bnc_level", btn_level, 1'b0);
      checkOutput("bnc_stall", bus.stall, 1'b1);
    end
    conf_btn = 1'b0;
    for (int i = 0; i < 10; i++) nextCycle();
    conf_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      nextCycle();
      checkOutput("bnc_press_level", btn_level, (i >= 22));
    end
    checkOutput("bnc_capture", bus.rdata, 32'h0000_000A);
    conf_btn = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      nextCycle();
      checkOutput("bnc_rel_valid", bus.rdata_valid, (j == 23));
      if (j == 23) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Held button: button-level read sees 1, then a key load accepted while
    // held needs a release and a fresh press.
    conf_btn = 1'b1;
    for (int i = 0; i < 25; i++) nextCycle();
    applyStimulus(1'b1, 1'b0, BTN_A, 32'h0);
    #1;
    checkOutput("btnrd_stall", bus.stall, 1'b1);
    nextCycle();
    checkOutput("btnrd_valid", bus.rdata_valid, 1'b1);
    checkOutput("btnrd_rdata", bus.rdata, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    key_data = 5'h05;
    applyStimulus(1'b1, 1'b0, KEY_A, 32'h0);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput("held_stall", bus.stall, 1'b1);
      checkOutput("held_valid", bus.rdata_valid, 1'b0);
    end
    conf_btn = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      nextCycle();
      checkOutput("held_rel_stall", bus.stall, 1'b1);
      checkOutput("held_rel_valid", bus.rdata_valid, 1'b0);
    end
    checkOutput("held_no_capture", bus.rdata, 32'h1);
    key_data = 5'h1B;
    conf_btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      nextCycle();
      checkOutput("held_press_stall", bus.stall, 1'b1);
    end
    checkOutput("held_capture", bus.rdata, 32'h0000_001B);
    conf_btn = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      nextCycle();
      checkOutput("held_done_valid", bus.rdata_valid, (j == 23));
      if (j == 23) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    end

    // Reset pulsed during MEM_WAIT, then a normal memory load.
    mem_rdata = 32'hCAFE_F00D;
    applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    #1;
    checkOutput("mr_c0_stall", bus.stall, 1'b1);
    nextCycle();
    checkOutput("mr_c1_mem_re", mem_re, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_rst_stall", bus.stall, 1'b0);
    checkOutput("mr_rst_mem_re", mem_re, 1'b0);
    checkOutput("mr_rst_rdata", bus.rdata, 32'h0);
    checkOutput("mr_rst_valid", bus.rdata_valid, 1'b0);
    checkOutput("mr_rst_btn_level", btn_level, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("mr_after_valid", bus.rdata_valid, 1'b0);
    mem_rdata = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    #1;
    checkOutput("mr2_c0_mem_re", mem_re, 1'b1);
    nextCycle();
    checkOutput("mr2_c1_stall", bus.stall, 1'b1);
    nextCycle();
    checkOutput("mr2_c2_stall", bus.stall, 1'b1);
    nextCycle();
    checkOutput("mr2_c3_valid", bus.rdata_valid, 1'b1);
    checkOutput("mr2_c3_rdata", bus.rdata, 32'h1234_5678);
    checkOutput("mr2_c3_stall", bus.stall, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_access_ctrl.md
# mmio_access_ctrl

Sequencing controller between the CPU's load/store stage and the memory/IO datapath. It decodes each access as data memory, LED, segment display, switch, key or confirm button. It stalls the CPU for data memory read latency and for confirm-button handshakes on switch/key reads, and emits single-cycle strobes to the IO write ports. Read data returns through a registered `rdata` path, which the writeback mux takes instead of the raw memory/IO lines.

## Interface
Parameters:
- `MEM_WAIT`, 1: cycles from read accept to `mem_rdata` valid; minimum 1.
- `DEBOUNCE_CYCLES`, 20: stable cycles required for a confirm-button level change. Board build uses 1_000_000.
- `LED_ADDR`, 32'hFFFF_FC60: LED write address.
- `SWITCH_ADDR`, 32'hFFFF_FC70: switch read address.
- `KEY_ADDR`, 32'hFFFF_FC74: key read address.
- `SEG_ADDR`, 32'hFFFF_FC80: segment display write address.
- `BTN_ADDR`, 32'hFFFF_FC84: confirm-button level read address.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_read` in 1: load in the current instruction.
- `req_write` in 1: store in the current instruction.
- `req_addr` in 32: byte address from the ALU. Held stable by the CPU while `stall`=1.
- `req_wdata` in 32: store data. Held stable by the CPU while `stall`=1.
- `mem_rdata` in 32: data memory read data.
- `switch_data` in 16: switch levels.
- `key_data` in 5: key code.
- `conf_btn` in 1: raw confirm button, asynchronous to `clk`.
- `stall` out 1: freezes the PC and pipeline.
- `mem_re` out 1: data memory read enable.
- `mem_we` out 1: data memory write enable.
- `led_we` out 1: one-cycle LED load strobe.
- `seg_we` out 1: one-cycle segment display load strobe.
- `wdata` out 32: equals `req_wdata`.
- `rdata` out 32: registered load result.
- `rdata_valid` out 1: `rdata` is to be written back this cycle.
- `btn_level` out 1: debounced button level.

## Operation
- **IO region:** `req_addr[31:10]`=22'h3FFFFF. Any other address is data memory.
  - IO-region addresses that match no parameter read 0 and ignore writes.
- **Read/write conflict:** `req_read` and `req_write` both high is treated as a write only.
- **Button front end:** 2-FF synchronizer, then debounce counter.
  - `btn_level` toggles after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing cycle clears the counter.
- **States:** IDLE, MEM_WAIT, BTN_PRESS, BTN_RELEASE, DONE.
- **IDLE, write:** stays in IDLE; `stall`=0. Exactly one of the following, combinational in that cycle:
  - memory: `mem_we`=1;
  - `LED_ADDR`: `led_we`=1;
  - `SEG_ADDR`: `seg_we`=1.
  - Writes to switch, key or button addresses have no effect.
- **IDLE, read:** `stall`=1 combinationally in the accept cycle.
  - Memory: `mem_re`=1, go to MEM_WAIT, wait counter=1.
  - Switch or key: go to BTN_PRESS.
  - Button or unmapped IO: `rdata` <= {31'b0, `btn_level`} or 0, go to DONE.
- **MEM_WAIT:** `stall`=1, `mem_re`=1.
  - When the counter equals `MEM_WAIT`: `rdata` <= `mem_rdata`, go to DONE.
  - Otherwise the counter increments.
- **BTN_PRESS:** `stall`=1. On `btn_level` rising (0 to 1):
  - switch: `rdata` <= {16'b0, `switch_data`};
  - key: `rdata` <= {27'b0, `key_data`};
  - then go to BTN_RELEASE.
- **Button already held:** if `btn_level` is already 1 on entry, the controller waits for release and a fresh press. Only a 0 to 1 transition observed in this state counts.
- **BTN_RELEASE:** `stall`=1. When `btn_level`=0, go to DONE. This prevents one press from confirming two reads.
- **DONE:** `stall`=0, `rdata_valid`=1 for exactly one cycle, then IDLE.
  - The request still present in DONE is not re-accepted.
  - A new request is evaluated from the following cycle.
- **No request** (`req_read`=`req_write`=0) in IDLE: all strobes 0, `stall`=0.

## Timing
- **Reset values:**
  - outputs: `stall`, `mem_re`, `mem_we`, `led_we`, `seg_we`, `rdata_valid`, `btn_level` = 0; `rdata` = 0;
  - internal: state IDLE, synchronizer 0, debounce and wait counters 0.
- **Reset mid-operation:** asserting `rst_n` low in any state returns everything to reset values immediately. Any pending read is dropped.
- **Store latency:** 0 extra cycles. Strobes coincide with the accept cycle.
- **Memory load:** accept at cycle 0, `rdata_valid` at cycle `MEM_WAIT`+1; `stall` high for cycles 0..`MEM_WAIT`.
- **Button or unmapped load:** `rdata_valid` at cycle 1; `stall` high for cycle 0 only.
- **Switch/key load:** unbounded wait. `btn_level` lags `conf_btn` by 2+`DEBOUNCE_CYCLES` cycles. Capture happens in the cycle `btn_level` is first seen high.
- **Output types:** `stall`, `mem_re`, `mem_we`, `led_we` and `seg_we` are combinational from state and request. `rdata` and `rdata_valid` are registered.

## Test plan
- **Memory load:** `MEM_WAIT`=2, load 0x0000_0010 with `mem_rdata`=0xDEADBEEF. Required: `stall`=1 for 3 cycles, then `rdata_valid`=1 and `rdata`=0xDEADBEEF, then `stall`=0.
- **IO stores:** back-to-back stores to `LED_ADDR` (0x00A5) and `SEG_ADDR` (0x1234). Required: `led_we` then `seg_we`, one cycle each, `wdata` matching, `stall` never 1.
- **Switch load:** load `SWITCH_ADDR` with `switch_data`=0xBEEF, button pressed 50 cycles then released. Required:
  - `rdata`=0x0000BEEF, captured at the debounced press;
  - `rdata_valid` only after the debounced release;
  - `stall` continuous until DONE.
- **Bounce rejection:** `conf_btn` toggling every 5 cycles with `DEBOUNCE_CYCLES`=20. Required: `btn_level` stays 0 and the key load stays stalled.
- **Held button:** button already held when the key load is accepted. Required: no capture until release followed by a new press; `key_data`=5'h1B then gives `rdata`=0x1B.
- **Reset mid-operation:** `rst_n` pulsed low during MEM_WAIT. Required: all outputs 0 at once; the next load executes normally.
